// File: rtl/drm_bus_axi4st_scheduler.sv
// Single-outstanding request scheduler between the DRM controller stream and NB_IP
// activator ports. Each request goes to one port and yields exactly one response word.
module drm_bus_axi4st_scheduler #(
  parameter int NB_IP          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  drm_aclk,
  input  logic                  drm_arstn,
  input  logic [31:0]           s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [31:0]           m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [NB_IP*32-1:0]   ip_tdata,
  output logic [NB_IP-1:0]      ip_tvalid,
  input  logic [NB_IP-1:0]      ip_tready,
  input  logic [NB_IP*32-1:0]   ip_rsp_tdata,
  input  logic [NB_IP-1:0]      ip_rsp_tvalid,
  output logic [NB_IP-1:0]      ip_rsp_tready,
  output logic                  drm_intr,
  output logic                  timeout_err,
  output logic [1:0]            dbg_state
);

  // Handshake: on every stream a beat transfers on a rising edge where tvalid and
  // tready are both high; a source holds tdata stable while tvalid=1 and tready=0.

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    RESP     = 2'd3
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [2:0]           idx_q;
  logic [NB_IP-1:0]     sel_oh;
  logic [15:0]          timer;
  logic [NB_IP-1:0]     intr_vec;

  logic [2:0]           req_idx;
  logic                 req_ok;
  logic [NB_IP-1:0]     req_oh;
  logic [NB_IP*32-1:0]  req_ip_tdata;
  logic [31:0]          sel_rsp;
  logic                 sel_rsp_valid;
  logic                 ack_hit;
  logic                 unused_bits;

  assign req_idx   = s_tdata[10:8];
  assign req_ok    = ({29'd0, req_idx} < NB_IP);
  assign dbg_state = state;

  // Decode the target port and build the forwarded word {26'b0, CS, CYC, ADR, WE, DAT}.
  always_comb begin
    req_oh       = '0;
    req_ip_tdata = '0;
    for (int i = 0; i < NB_IP; i++) begin
      if (req_idx == 3'(i)) begin
        req_oh[i]                = 1'b1;
        req_ip_tdata[i*32 +: 32] = {26'd0, s_tdata[5:0]};
      end
    end
  end

  // Response stream of the port that owns the outstanding request.
  always_comb begin
    sel_rsp       = '0;
    sel_rsp_valid = 1'b0;
    for (int i = 0; i < NB_IP; i++) begin
      if (sel_oh[i]) begin
        sel_rsp       = sel_rsp | ip_rsp_tdata[i*32 +: 32];
        sel_rsp_valid = sel_rsp_valid | ip_rsp_tvalid[i];
      end
    end
  end

  assign ack_hit     = sel_rsp_valid & sel_rsp[3];
  assign unused_bits = ^{s_tdata[31:11], s_tdata[7:6], sel_rsp[31:4]};

  function automatic logic [31:0] fmt_resp(input logic dat, input logic sta,
                                           input logic err, input logic intr,
                                           input logic [2:0] idx);
    return {24'd0, err, idx, 1'b1, intr, sta, dat};
  endfunction

  always_ff @(posedge drm_aclk or negedge drm_arstn) begin
    if (!drm_arstn) begin
      state         <= IDLE;
      s_tready      <= 1'b0;
      m_tvalid      <= 1'b0;
      m_tdata       <= '0;
      ip_tvalid     <= '0;
      ip_tdata      <= '0;
      ip_rsp_tready <= '0;
      timer         <= '0;
      idx_q         <= '0;
      sel_oh        <= '0;
      timeout_err   <= 1'b0;
    end else begin
      ip_rsp_tready <= '1;
      timeout_err   <= 1'b0;
      case (state)
        IDLE: begin
          s_tready <= 1'b1;
          if (s_tvalid && s_tready) begin
            s_tready <= 1'b0;
            idx_q    <= req_idx;
            if (req_ok) begin
              state     <= ISSUE;
              sel_oh    <= req_oh;
              ip_tvalid <= req_oh;
              ip_tdata  <= req_ip_tdata;
            end else begin
              // Nonexistent port: answer straight away with an error response.
              state    <= RESP;
              sel_oh   <= '0;
              m_tvalid <= 1'b1;
              m_tdata  <= fmt_resp(1'b0, 1'b0, 1'b1, drm_intr, req_idx);
            end
          end
        end
        ISSUE: begin
          if (|(ip_tready & sel_oh)) begin
            ip_tvalid <= '0;
            ip_tdata  <= '0;
            timer     <= '0;
            state     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // An ACK wins over a timeout expiring on the same edge.
          if (ack_hit) begin
            state    <= RESP;
            m_tvalid <= 1'b1;
            m_tdata  <= fmt_resp(sel_rsp[0], sel_rsp[1], 1'b0, drm_intr, idx_q);
          end else if (timer == TIMER_LAST) begin
            timer       <= timer + 16'd1;
            state       <= RESP;
            timeout_err <= 1'b1;
            m_tvalid    <= 1'b1;
            m_tdata     <= fmt_resp(1'b0, 1'b0, 1'b1, drm_intr, idx_q);
          end else begin
            timer <= timer + 16'd1;
          end
        end
        RESP: begin
          if (m_tready) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            s_tready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Interrupt bits are sampled from any valid response beat, in every state.
  always_ff @(posedge drm_aclk or negedge drm_arstn) begin
    if (!drm_arstn) begin
      intr_vec <= '0;
      drm_intr <= 1'b0;
    end else begin
      for (int i = 0; i < NB_IP; i++) begin
        if (ip_rsp_tvalid[i]) intr_vec[i] <= ip_rsp_tdata[i*32 + 2];
      end
      drm_intr <= |intr_vec;
    end
  end

endmodule

// File: tb/tb_drm_bus_axi4st_scheduler.sv
// Directed bench for drm_bus_axi4st_scheduler: transaction-level response model,
// expected-response queue, per-cycle output compare process and a final report.
module tb_drm_bus_axi4st_scheduler;

  localparam int NB_IP = 4;
  localparam int TO    = 16;

  logic                 drm_aclk = 1'b0;
  logic                 drm_arstn = 1'b0;
  logic [31:0]          s_tdata = '0;
  logic                 s_tvalid = 1'b0;
  logic                 s_tready;
  logic [31:0]          m_tdata;
  logic                 m_tvalid;
  logic                 m_tready = 1'b0;
  logic [NB_IP*32-1:0]  ip_tdata;
  logic [NB_IP-1:0]     ip_tvalid;
  logic [NB_IP-1:0]     ip_tready = '0;
  logic [NB_IP*32-1:0]  ip_rsp_tdata = '0;
  logic [NB_IP-1:0]     ip_rsp_tvalid = '0;
  logic [NB_IP-1:0]     ip_rsp_tready;
  logic                 drm_intr;
  logic                 timeout_err;
  logic [1:0]           dbg_state;

  drm_bus_axi4st_scheduler #(.NB_IP(NB_IP), .TIMEOUT_CYCLES(TO)) dut (
    .drm_aclk(drm_aclk), .drm_arstn(drm_arstn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .ip_tdata(ip_tdata), .ip_tvalid(ip_tvalid), .ip_tready(ip_tready),
    .ip_rsp_tdata(ip_rsp_tdata), .ip_rsp_tvalid(ip_rsp_tvalid), .ip_rsp_tready(ip_rsp_tready),
    .drm_intr(drm_intr), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 drm_aclk = ~drm_aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int               n_cmp = 0;
  int               n_bad = 0;
  logic [31:0]      exp_q[$];
  int               to_seen = 0;
  int               to_exp = 0;
  logic [NB_IP-1:0] model_intr = '0;
  logic             held_v = 1'b0;
  logic [31:0]      held_d = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event did not occur as required (t=%0t)", name, $time);
  endtask

  // Expected response word derived from the request, the activator's behaviour and
  // the interrupt lines the bench has driven.
  function automatic logic [31:0] model_resp(input logic [31:0] req, input bit acked,
                                             input logic [31:0] rsp, input bit intr);
    logic [31:0] w;
    bit err;
    err    = (int'(req[10:8]) >= NB_IP) || !acked;
    w      = '0;
    w[0]   = err ? 1'b0 : rsp[0];
    w[1]   = err ? 1'b0 : rsp[1];
    w[2]   = intr;
    w[3]   = 1'b1;
    w[6:4] = req[10:8];
    w[7]   = err;
    return w;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge drm_aclk) begin
    if (drm_arstn) begin
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) fail_now("unexpected_response");
        else check("m_tdata", m_tdata, exp_q.pop_front());
      end
      if (held_v && m_tvalid) check("m_tdata_stable", m_tdata, held_d);
      held_v = m_tvalid && !m_tready;
      held_d = m_tdata;
      check("s_tready_excl", {s_tready && m_tvalid, s_tready && (|ip_tvalid)}, 0);
      check("ip_tvalid_onehot", ($countones(ip_tvalid) <= 1), 1);
      if (timeout_err) to_seen++;
    end else begin
      held_v = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge drm_aclk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_tready"}, s_tready, 0);
    check({tag, "_m_tvalid"}, m_tvalid, 0);
    check({tag, "_m_tdata"}, m_tdata, 0);
    check({tag, "_ip_tvalid"}, ip_tvalid, 0);
    check({tag, "_ip_tdata"}, ip_tdata, 0);
    check({tag, "_ip_rsp_tready"}, ip_rsp_tready, 0);
    check({tag, "_drm_intr"}, drm_intr, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  task automatic drive_rsp(input int port, input logic [31:0] word);
    ip_rsp_tvalid[port]            = 1'b1;
    ip_rsp_tdata[port*32 +: 32]    = word;
    model_intr[port]               = word[2];
  endtask

  task automatic clear_rsp();
    ip_rsp_tvalid = '0;
    ip_rsp_tdata  = '0;
  endtask

  // One full transaction. ack_dly<0 means the activator never acknowledges.
  // junk drives non-ACK / foreign-port responses in the first wait cycle.
  task automatic do_txn(input logic [31:0] req, input int tr_dly, input int ack_dly,
                        input logic [31:0] rsp, input int hold, input bit junk,
                        input bit use_lit, input logic [31:0] lit);
    int idx;
    int n;
    bit acked;
    logic [NB_IP-1:0]    exp_v;
    logic [NB_IP*32-1:0] exp_ip;
    idx   = int'(req[10:8]);
    acked = (idx < NB_IP) && (ack_dly >= 0);
    exp_q.push_back(use_lit ? lit : model_resp(req, acked, rsp, |model_intr));
    s_tdata  = req;
    s_tvalid = 1'b1;
    n = 0;
    while (!s_tready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) fail_now("accept_timeout");
    tick();
    s_tvalid = 1'b0;
    s_tdata  = '0;
    if (idx < NB_IP) begin
      exp_v  = '0;
      exp_v[idx] = 1'b1;
      exp_ip = '0;
      exp_ip[idx*32 +: 32] = {26'd0, req[5:0]};
      for (int i = 0; i <= tr_dly; i++) begin
        check("issue_ip_tvalid", ip_tvalid, exp_v);
        check("issue_ip_tdata", ip_tdata, exp_ip);
        check("issue_m_tvalid", m_tvalid, 0);
        if (i == tr_dly) ip_tready[idx] = 1'b1;
        tick();
      end
      ip_tready = '0;
      check("wait_ip_tvalid", ip_tvalid, 0);
      if (acked) begin
        for (int i = 0; i < ack_dly; i++) begin
          if (junk && i == 0) begin
            for (int p = 0; p < NB_IP; p++) drive_rsp(p, (p == idx) ? 32'h3 : 32'hB);
          end
          tick();
          clear_rsp();
          check("wait_m_tvalid", m_tvalid, 0);
        end
        drive_rsp(idx, rsp);
        tick();
        clear_rsp();
        check("ack_latency_m_tvalid", m_tvalid, 1);
        check("ack_no_timeout", timeout_err, 0);
      end else begin
        for (int i = 0; i < TO - 1; i++) begin
          tick();
          check("to_wait_m_tvalid", m_tvalid, 0);
          check("to_wait_timeout_err", timeout_err, 0);
        end
        tick();
        check("to_m_tvalid", m_tvalid, 1);
        check("to_pulse", timeout_err, 1);
        to_exp++;
      end
    end else begin
      check("badidx_m_tvalid", m_tvalid, 1);
      check("badidx_ip_tvalid", ip_tvalid, 0);
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_s_tready", s_tready, 0);
      check("hold_m_tvalid", m_tvalid, 1);
      check("hold_timeout_err", timeout_err, 0);
    end
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    check("post_m_tvalid", m_tvalid, 0);
    check("post_timeout_err", timeout_err, 0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    tick();
    tick();
    check_reset_outputs("rst");
    drm_arstn = 1'b1;
    check("rst_release_s_tready", s_tready, 0);
    tick();
    check("first_edge_s_tready", s_tready, 1);
    check("first_edge_ip_rsp_tready", ip_rsp_tready, 4'hF);

    // Write to port 2, ACK one cycle after tready: response visible at cycle 3.
    do_txn(32'h0000_0233, 0, 0, 32'h8, 0, 0, 1, 32'h0000_0028);
    // Read from port 1 with ignored non-ACK / foreign responses first.
    do_txn(32'h0000_0131, 2, 3, 32'h0000_000B, 0, 1, 1, 32'h0000_001B);
    // Nonexistent port.
    do_txn(32'h0000_0733, 0, 0, 32'h0, 0, 0, 1, 32'h0000_00F8);
    // No ACK at all: timeout.
    do_txn(32'h0000_0010, 0, -1, 32'h0, 2, 0, 1, 32'h0000_0088);
    // ACK in the last wait cycle beats the timeout.
    do_txn(32'h0000_0321, 1, TO - 1, 32'h9, 0, 0, 1, 32'h0000_0039);

    // Model-checked sweep over all ports with varying delays and upper junk bits.
    for (int p = 0; p < NB_IP; p++) begin
      do_txn(32'(p << 8) | 32'((p * 13 + 5) & 63) | 32'hFF00_F8C0,
             p % 3, p, 32'hABCD_0008 | 32'(p & 3), p, (p > 0), 0, 32'h0);
    end

    // Interrupt from an idle response on port 3.
    drive_rsp(3, 32'h4);
    tick();
    clear_rsp();
    check("intr_lag", drm_intr, 0);
    tick();
    check("intr_set", drm_intr, 1);
    do_txn(32'h0000_0131, 0, 0, 32'h0000_000B, 0, 0, 1, 32'h0000_001F);
    check("intr_still_set", drm_intr, 1);
    drive_rsp(3, 32'h0);
    tick();
    clear_rsp();
    tick();
    check("intr_clear", drm_intr, 0);

    // Long stall on the response channel.
    do_txn(32'h0000_0215, 0, 1, 32'h0000_000A, 10, 0, 1, 32'h0000_002A);

    // Reset in the middle of WAIT_ACK aborts the transaction.
    s_tdata  = 32'h0000_0003;
    s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
    ip_tready[0] = 1'b1;
    tick();
    ip_tready = '0;
    tick();
    check("abort_pre_ip_tvalid", ip_tvalid, 0);
    #1;
    drm_arstn  = 1'b0;
    model_intr = '0;
    #1;
    check_reset_outputs("abort");
    tick();
    tick();
    drm_arstn = 1'b1;
    tick();
    check("abort_recover_s_tready", s_tready, 1);
    drive_rsp(0, 32'h8);
    m_tready = 1'b1;
    tick();
    clear_rsp();
    for (int i = 0; i < 20; i++) begin
      check("abort_no_resp", m_tvalid, 0);
      tick();
    end
    m_tready = 1'b0;
    do_txn(32'h0000_0322, 0, 2, 32'h9, 1, 1, 0, 32'h0);

    // ---------------- final report ----------------
    tick();
    tick();
    check("exp_q_drained", exp_q.size(), 0);
    check("timeout_pulse_count", to_seen, to_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
